// File: rtl/qtu_fmb_table.sv
// ---------------------------------------------------------------------------
// qtu_fmb_table -- Q-table update and find-my-best (FMB) next-hop engine.
//
// Holds up to MAX_NEIGHBORS neighbour entries (id, hops, energy, q, hCH).
// Each accepted packet is looked up in the table, written (match / free
// slot / replace-min-q), and then the table is scanned one entry per cycle
// to elect the best next hop toward the cluster head.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   one-cycle packet strobe, sampled only in IDLE
//   iAmDestination       node is the cluster head; election bypassed
//   HB_Reset             heartbeat; synchronously clears the table
//   f*                   received packet fields
//   chosenCH, hopsFromCH own cluster head and own hop distance to it
//   node*, neighborIndex contents / slot of the entry last written
//   neighborCount        number of valid entries
//   chosenHop, bestQ     elected next hop and its Q-value
//   dropped              last packet discarded because the table was full
//   QTUFMB_done          one-cycle completion pulse
//
// Optional feature: define QTU_FMB_ENERGY_TIEBREAK_EN to break equal-q ties
// on higher energy before lower hops.
// ---------------------------------------------------------------------------

// One table slot. Clear wins over write.
module qtu_fmb_entry #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clear,
    input  logic         we,
    input  logic [W-1:0] wid,
    input  logic [W-1:0] whops,
    input  logic [W-1:0] wenergy,
    input  logic [W-1:0] wq,
    input  logic [W-1:0] whch,
    output logic         valid,
    output logic [W-1:0] id,
    output logic [W-1:0] hops,
    output logic [W-1:0] energy,
    output logic [W-1:0] q,
    output logic [W-1:0] hch
);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid  <= 1'b0;
            id     <= '0;
            hops   <= '0;
            energy <= '0;
            q      <= '0;
            hch    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (we) begin
            valid  <= 1'b1;
            id     <= wid;
            hops   <= whops;
            energy <= wenergy;
            q      <= wq;
            hch    <= whch;
        end
    end
endmodule

module qtu_fmb_table #(
    parameter  int WORD_WIDTH    = 16,
    parameter  int MAX_NEIGHBORS = 32,
    localparam int IDX_W         = $clog2(MAX_NEIGHBORS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  iAmDestination,
    input  logic                  HB_Reset,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fHopsFromCH,
    input  logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [IDX_W-1:0]      neighborIndex,
    output logic [IDX_W:0]        neighborCount,
    output logic [WORD_WIDTH-1:0] chosenHop,
    output logic [WORD_WIDTH-1:0] bestQ,
    output logic                  dropped,
    output logic                  QTUFMB_done
);
    localparam int W = WORD_WIDTH;
    localparam int N = MAX_NEIGHBORS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITE, S_SCAN, S_DONE} state_t;
    typedef enum logic [1:0] {K_FOREIGN, K_MATCH, K_FREE, K_FULL} kind_t;

    state_t state, state_nxt;

    // Captured packet
    logic [W-1:0] c_id, c_hops, c_q, c_energy, c_hch, c_ch;

    // Table storage
    logic [N-1:0]        t_valid;
    logic [N-1:0][W-1:0] t_id, t_hops, t_energy, t_q, t_hch;
    logic [N-1:0]        t_we;

    // Lookup result, latched in LOOKUP and consumed in WRITE
    kind_t            lk_kind;
    logic [IDX_W-1:0] lk_idx;

    // Scan state
    logic [IDX_W-1:0] scan_idx;
    logic             best_valid;
    logic [W-1:0]     best_id, best_q, best_hops;
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
    logic [W-1:0]     best_energy;
`endif

    logic wr_go;

    generate
        for (genvar g = 0; g < N; g++) begin : g_entry
            qtu_fmb_entry #(.W(W)) u_entry (
                .clk     (clk),
                .nrst    (nrst),
                .clear   (HB_Reset),
                .we      (t_we[g]),
                .wid     (c_id),
                .whops   (c_hops),
                .wenergy (c_energy),
                .wq      (c_q),
                .whch    (c_hch),
                .valid   (t_valid[g]),
                .id      (t_id[g]),
                .hops    (t_hops[g]),
                .energy  (t_energy[g]),
                .q       (t_q[g]),
                .hch     (t_hch[g])
            );
        end
    endgenerate

    // The last-written slot still holds exactly what was written, so the
    // node* outputs simply read it back.
    assign nodeID     = t_id[neighborIndex];
    assign nodeHops   = t_hops[neighborIndex];
    assign nodeEnergy = t_energy[neighborIndex];
    assign nodeQValue = t_q[neighborIndex];

    // ---------------- parallel lookup ----------------
    // Loops run high-to-low so the last hit assigned is the lowest index.
    logic             lk_match_hit, lk_free_hit;
    logic [IDX_W-1:0] lk_match_idx, lk_free_idx, lk_min_idx;
    logic [W-1:0]     lk_min_q;

    always_comb begin
        lk_match_hit = 1'b0;
        lk_match_idx = '0;
        lk_free_hit  = 1'b0;
        lk_free_idx  = '0;
        lk_min_q     = '1;
        lk_min_idx   = LAST_IDX;
        for (int i = N - 1; i >= 0; i--) begin
            if (t_valid[i] && t_id[i] == c_id) begin
                lk_match_hit = 1'b1;
                lk_match_idx = IDX_W'(i);
            end
            if (!t_valid[i]) begin
                lk_free_hit = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
            if (t_q[i] <= lk_min_q) begin
                lk_min_q   = t_q[i];
                lk_min_idx = IDX_W'(i);
            end
        end
    end

    // ---------------- scan candidate ----------------
    logic [W-1:0] cand_id, cand_q, cand_hops;
    logic         cand_elig, cand_better, fin_valid;
    logic [W-1:0] fin_id, fin_q;

    always_comb begin
        cand_id   = t_id[scan_idx];
        cand_q    = t_q[scan_idx];
        cand_hops = t_hops[scan_idx];
        cand_elig = t_valid[scan_idx] && (t_hch[scan_idx] < hopsFromCH);
        // Strict comparisons keep the earlier (lower-index) entry on full ties.
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
        cand_better = cand_elig && (!best_valid || cand_q > best_q ||
                      (cand_q == best_q && (t_energy[scan_idx] > best_energy ||
                      (t_energy[scan_idx] == best_energy && cand_hops < best_hops))));
`else
        cand_better = cand_elig && (!best_valid || cand_q > best_q ||
                      (cand_q == best_q && cand_hops < best_hops));
`endif
        fin_valid = best_valid || cand_better;
        fin_id    = cand_better ? cand_id : best_id;
        fin_q     = cand_better ? cand_q  : best_q;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en) state_nxt = S_LOOKUP;
            S_LOOKUP: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (lk_kind == K_FOREIGN) ? S_DONE : S_SCAN;
            S_SCAN:   if (scan_idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (HB_Reset) state_nxt = S_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_go = 1'b0;
        if (state == S_WRITE) begin
            case (lk_kind)
                K_MATCH, K_FREE: wr_go = 1'b1;
                K_FULL:          wr_go = (c_q > t_q[lk_idx]);
                default:         wr_go = 1'b0;
            endcase
        end
        t_we = '0;
        if (wr_go) t_we[lk_idx] = 1'b1;
        QTUFMB_done = (state == S_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            c_id          <= '0;
            c_hops        <= '0;
            c_q           <= '0;
            c_energy      <= '0;
            c_hch         <= '0;
            c_ch          <= '0;
            lk_kind       <= K_FOREIGN;
            lk_idx        <= '0;
            scan_idx      <= '0;
            best_valid    <= 1'b0;
            best_id       <= '0;
            best_q        <= '0;
            best_hops     <= '0;
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
            best_energy   <= '0;
`endif
            neighborIndex <= '0;
            neighborCount <= '0;
            chosenHop     <= '1;
            bestQ         <= '0;
            dropped       <= 1'b0;
        end else if (HB_Reset) begin
            neighborCount <= '0;
            chosenHop     <= '1;
            bestQ         <= '0;
            best_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (en) begin
                    c_id     <= fSourceID;
                    c_hops   <= fSourceHops;
                    c_q      <= fQValue;
                    c_energy <= fEnergyLeft;
                    c_hch    <= fHopsFromCH;
                    c_ch     <= fChosenCH;
                end
                S_LOOKUP: begin
                    if (c_ch != chosenCH) begin
                        lk_kind <= K_FOREIGN;
                    end else if (lk_match_hit) begin
                        lk_kind <= K_MATCH;
                        lk_idx  <= lk_match_idx;
                    end else if (lk_free_hit) begin
                        lk_kind <= K_FREE;
                        lk_idx  <= lk_free_idx;
                    end else begin
                        lk_kind <= K_FULL;
                        lk_idx  <= lk_min_idx;
                    end
                end
                S_WRITE: begin
                    scan_idx   <= '0;
                    best_valid <= 1'b0;
                    if (lk_kind == K_FOREIGN) begin
                        dropped <= 1'b0;
                    end else if (wr_go) begin
                        neighborIndex <= lk_idx;
                        dropped       <= 1'b0;
                        if (lk_kind == K_FREE) neighborCount <= neighborCount + 1'b1;
                    end else begin
                        dropped <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (cand_better) begin
                        best_valid  <= 1'b1;
                        best_id     <= cand_id;
                        best_q      <= cand_q;
                        best_hops   <= cand_hops;
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
                        best_energy <= t_energy[scan_idx];
`endif
                    end
                    if (scan_idx == LAST_IDX) begin
                        scan_idx <= '0;
                        // Result lands together with the done pulse.
                        if (iAmDestination || !fin_valid) begin
                            chosenHop <= chosenCH;
                            bestQ     <= '0;
                        end else begin
                            chosenHop <= fin_id;
                            bestQ     <= fin_q;
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qtu_fmb_table.sv
`timescale 1ns/1ps
module tb_qtu_fmb_table;
    localparam int W  = 16;
    localparam int N  = 32;
    localparam int IW = $clog2(N);

    logic clk = 1'b0, nrst = 1'b1, en = 1'b0, iAmDestination = 1'b0, HB_Reset = 1'b0;
    logic [W-1:0] fSourceID = '0, fSourceHops = '0, fQValue = '0, fEnergyLeft = '0;
    logic [W-1:0] fHopsFromCH = '0, fChosenCH = '0, chosenCH = '0, hopsFromCH = '0;
    logic [W-1:0] nodeID, nodeHops, nodeEnergy, nodeQValue, chosenHop, bestQ;
    logic [IW-1:0] neighborIndex;
    logic [IW:0]   neighborCount;
    logic          dropped, QTUFMB_done;

    always #5 clk = ~clk;

    qtu_fmb_table #(.WORD_WIDTH(W), .MAX_NEIGHBORS(N)) dut (
        .clk(clk), .nrst(nrst), .en(en), .iAmDestination(iAmDestination),
        .HB_Reset(HB_Reset), .fSourceID(fSourceID), .fSourceHops(fSourceHops),
        .fQValue(fQValue), .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH),
        .fChosenCH(fChosenCH), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
        .nodeID(nodeID), .nodeHops(nodeHops), .nodeEnergy(nodeEnergy),
        .nodeQValue(nodeQValue), .neighborIndex(neighborIndex),
        .neighborCount(neighborCount), .chosenHop(chosenHop), .bestQ(bestQ),
        .dropped(dropped), .QTUFMB_done(QTUFMB_done)
    );

    int n_chk = 0, n_pass = 0;

    // Reference model of the neighbour table and outputs
    bit           m_valid [N];
    logic [W-1:0] m_id [N], m_hops [N], m_energy [N], m_q [N], m_hch [N];
    int           m_count, m_nidx;
    logic [W-1:0] m_hop, m_bestq, m_nid, m_nhops, m_nenergy, m_nq;
    bit           m_dropped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_id[i] = 0; m_hops[i] = 0; m_energy[i] = 0; m_q[i] = 0; m_hch[i] = 0;
        end
        m_count = 0; m_nidx = 0; m_hop = '1; m_bestq = 0; m_dropped = 0;
        m_nid = 0; m_nhops = 0; m_nenergy = 0; m_nq = 0;
    endtask

    task automatic model_hb();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_count = 0; m_hop = '1; m_bestq = 0;
    endtask

    task automatic model_write(input logic [W-1:0] id, hops, q, energy, hch, fch,
                               output bit foreign);
        int slot = -1;
        bit fresh = 0;
        foreign = (fch != chosenCH);
        if (foreign) begin m_dropped = 0; return; end
        for (int i = 0; i < N; i++) if (slot < 0 && m_valid[i] && m_id[i] == id) slot = i;
        if (slot < 0)
            for (int i = 0; i < N; i++) if (slot < 0 && !m_valid[i]) begin slot = i; fresh = 1; end
        if (slot < 0) begin
            slot = 0;
            for (int i = 1; i < N; i++) if (m_q[i] < m_q[slot]) slot = i;
            if (q <= m_q[slot]) begin m_dropped = 1; return; end
        end
        m_valid[slot] = 1; m_id[slot] = id; m_hops[slot] = hops;
        m_energy[slot] = energy; m_q[slot] = q; m_hch[slot] = hch;
        if (fresh) m_count++;
        m_dropped = 0; m_nidx = slot;
        m_nid = id; m_nhops = hops; m_nenergy = energy; m_nq = q;
    endtask

    function automatic bit elig(input int i);
        return m_valid[i] && (m_hch[i] < hopsFromCH);
    endfunction

    // Election by successive filtering: best q, (best energy), fewest hops, first index.
    task automatic model_elect();
        bit any = 0;
        logic [W-1:0] topq = 0, tope = 0, toph = '1;
        int win = -1;
        if (iAmDestination) begin m_hop = chosenCH; m_bestq = 0; return; end
        for (int i = 0; i < N; i++)
            if (elig(i) && (!any || m_q[i] > topq)) begin any = 1; topq = m_q[i]; end
        if (!any) begin m_hop = chosenCH; m_bestq = 0; return; end
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
        for (int i = 0; i < N; i++)
            if (elig(i) && m_q[i] == topq && m_energy[i] > tope) tope = m_energy[i];
        for (int i = 0; i < N; i++)
            if (elig(i) && m_q[i] == topq && m_energy[i] == tope && m_hops[i] <= toph) toph = m_hops[i];
        for (int i = 0; i < N; i++)
            if (win < 0 && elig(i) && m_q[i] == topq && m_energy[i] == tope && m_hops[i] == toph) win = i;
`else
        for (int i = 0; i < N; i++)
            if (elig(i) && m_q[i] == topq && m_hops[i] <= toph) toph = m_hops[i];
        for (int i = 0; i < N; i++)
            if (win < 0 && elig(i) && m_q[i] == topq && m_hops[i] == toph) win = i;
`endif
        m_hop = m_id[win]; m_bestq = m_q[win];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".chosenHop"}, chosenHop, m_hop);
        chk({tag, ".bestQ"}, bestQ, m_bestq);
        chk({tag, ".count"}, neighborCount, m_count);
        chk({tag, ".dropped"}, dropped, m_dropped);
        chk({tag, ".nodeID"}, nodeID, m_nid);
        chk({tag, ".nodeHops"}, nodeHops, m_nhops);
        chk({tag, ".nodeEnergy"}, nodeEnergy, m_nenergy);
        chk({tag, ".nodeQ"}, nodeQValue, m_nq);
        chk({tag, ".index"}, neighborIndex, m_nidx);
    endtask

    task automatic strobe(input logic [W-1:0] id, hops, q, energy, hch, fch, output bit foreign);
        @(negedge clk);
        fSourceID = id; fSourceHops = hops; fQValue = q;
        fEnergyLeft = energy; fHopsFromCH = hch; fChosenCH = fch; en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        model_write(id, hops, q, energy, hch, fch, foreign);
    endtask

    task automatic send(input logic [W-1:0] id, hops, q, energy, hch, fch, input string tag);
        bit foreign;
        int lat = -1;
        strobe(id, hops, q, energy, hch, fch, foreign);
        for (int c = 1; c <= N + 8; c++) begin
            @(posedge clk); #1;
            if (QTUFMB_done) begin lat = c; break; end
        end
        if (!foreign) model_elect();
        chk({tag, ".latency"}, lat, foreign ? 2 : N + 2);
        check_all(tag);
        @(posedge clk); #1 chk({tag, ".done_pulse"}, QTUFMB_done, 0);
    endtask

    task automatic hb();
        @(negedge clk); HB_Reset = 1'b1;
        @(negedge clk); HB_Reset = 1'b0;
        model_hb();
    endtask

    initial begin
        bit foreign, seen;
        // ---- reset ----
        #3 nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.chosenHop", chosenHop, 16'hFFFF);
        chk("reset.done", QTUFMB_done, 0);
        check_all("reset");
        nrst = 1'b1;

        // ---- heartbeat, then a foreign packet ----
        chosenCH = 16'd25; hopsFromCH = 16'd2;
        hb();
        send(16'd41, 16'd1, 16'h0100, 16'd5, 16'd1, 16'd41, "foreign");
        chk("foreign.count0", neighborCount, 0);
        chk("foreign.hopFFFF", chosenHop, 16'hFFFF);

        // ---- two neighbours ----
        send(16'd65, 16'd1, 16'h0C00, 16'd100, 16'd1, 16'd25, "n65");
        send(16'd71, 16'd1, 16'h0A00, 16'd100, 16'd1, 16'd25, "n71");
        chk("two.hop65", chosenHop, 16'd65);
        chk("two.bestq", bestQ, 16'h0C00);
        chk("two.count2", neighborCount, 2);

        // ---- resend 71 with higher Q: same slot ----
        send(16'd71, 16'd1, 16'h0E00, 16'd100, 16'd1, 16'd25, "re71");
        chk("re71.hop71", chosenHop, 16'd71);
        chk("re71.count2", neighborCount, 2);
        chk("re71.slot1", neighborIndex, 1);

        // ---- fill, drop, replace min ----
        hb();
        for (int i = 0; i < N; i++)
            send(W'(100 + i), 16'd1, W'(16'h0100 + i), 16'd10, 16'd1, 16'd25, "fill");
        chk("fill.countN", neighborCount, N);
        send(16'd200, 16'd1, 16'h0050, 16'd10, 16'd1, 16'd25, "lowq");
        chk("lowq.dropped", dropped, 1);
        send(16'd201, 16'd1, 16'h2000, 16'd10, 16'd1, 16'd25, "highq");
        chk("highq.slot0", neighborIndex, 0);
        chk("highq.hop201", chosenHop, 16'd201);
        chk("highq.notdropped", dropped, 0);

        // ---- nothing eligible / destination bypass ----
        hb();
        send(16'd300, 16'd1, 16'h0300, 16'd10, 16'd2, 16'd25, "inel2");
        send(16'd301, 16'd1, 16'h0400, 16'd10, 16'd5, 16'd25, "inel5");
        chk("inel.hop25", chosenHop, 16'd25);
        chk("inel.bestq0", bestQ, 0);
        iAmDestination = 1'b1;
        send(16'd302, 16'd1, 16'h0500, 16'd10, 16'd0, 16'd25, "dest");
        chk("dest.hop25", chosenHop, 16'd25);
        iAmDestination = 1'b0;

        // ---- equal-Q tie-break ----
        hb();
        send(16'd400, 16'd3, 16'h0500, 16'd900, 16'd1, 16'd25, "tieA");
        send(16'd401, 16'd1, 16'h0500, 16'd100, 16'd1, 16'd25, "tieB");
`ifdef QTU_FMB_ENERGY_TIEBREAK_EN
        chk("tie.energy", chosenHop, 16'd400);
`else
        chk("tie.hops", chosenHop, 16'd401);
`endif

        // ---- heartbeat mid-scan ----
        strobe(16'd402, 16'd2, 16'h0700, 16'd7, 16'd1, 16'd25, foreign);
        repeat (10) @(posedge clk);
        @(negedge clk); HB_Reset = 1'b1;
        @(negedge clk); HB_Reset = 1'b0;
        model_hb();
        seen = 0;
        repeat (N + 6) begin @(posedge clk); #1 if (QTUFMB_done) seen = 1; end
        chk("hbscan.no_done", seen, 0);
        chk("hbscan.count0", neighborCount, 0);
        check_all("hbscan");

        // ---- randomized packets ----
        for (int p = 0; p < 60; p++) begin
            hopsFromCH     = ($urandom_range(0, 1) == 0) ? 16'd2 : 16'd3;
            iAmDestination = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) hb();
            send(W'(500 + $urandom_range(0, 39)), W'($urandom_range(0, 3)),
                 W'($urandom_range(0, 7) << 8), W'($urandom_range(0, 3)),
                 W'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 16'd26 : 16'd25, "rand");
        end
        iAmDestination = 1'b0;

        // ---- async reset mid-scan ----
        strobe(16'd600, 16'd1, 16'h0900, 16'd3, 16'd1, 16'd25, foreign);
        repeat (10) @(posedge clk);
        @(negedge clk); nrst = 1'b0;
        #1;
        model_reset();
        chk("nrst.done", QTUFMB_done, 0);
        check_all("nrst");
        @(negedge clk); nrst = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1 chk("nrst.idle", QTUFMB_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
